// File: rtl/nx_ram_ecc_pkg.sv
// nx_ram_ecc_pkg: shared types and SECDED code-layout helpers
package nx_ram_ecc_pkg;
  typedef enum logic [1:0] {ECC_OK, ECC_CE, ECC_UE} ecc_status_e;
  typedef enum logic {ST_INIT, ST_READY} init_state_e;
  // Overall parity lives at codeword bit 0; Hamming position p lives at bit p
  localparam int OVERALL_POS = 0;
  function automatic int ecc_bits(int width);
    int p = 0;
    while ((1 << p) < width + p + 1) p++;
    return p + 1;
  endfunction
  function automatic logic is_parity_pos(int pos);
    return (pos & (pos - 1)) == 0;
  endfunction
  function automatic int data_pos(int i);
    int p = OVERALL_POS;
    int k = -1;
    while (k < i) begin
      p++;
      if (!is_parity_pos(p)) k++;
    end
    return p;
  endfunction
endpackage

// File: rtl/nx_secded_codec.sv
// nx_secded_codec: combinational SECDED encoder and decoder
module nx_secded_codec
  import nx_ram_ecc_pkg::*;
#(
  parameter int WIDTH = 83,
  localparam int P = ecc_bits(WIDTH) - 1,
  localparam int CW = WIDTH + P + 1
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    enc_o,
  input  logic [CW-1:0]    cw_i,
  input  logic             disable_i,
  output logic [WIDTH-1:0] data_o,
  output ecc_status_e      status_o
);
  logic [P-1:0] enc_syn, dec_syn;
  logic dec_par;
  int ke, kd;
  // Scatter data into non-power-of-two positions, then fill Hamming and overall parity
  always_comb begin
    enc_o = '0;
    enc_syn = '0;
    ke = 0;
    for (int p = 1; p < CW; p++)
      if (!is_parity_pos(p)) begin
        enc_o[p] = data_i[ke];
        ke++;
      end
    for (int p = 1; p < CW; p++)
      if (enc_o[p]) enc_syn = enc_syn ^ p[P-1:0];
    for (int j = 0; j < P; j++) enc_o[1 << j] = enc_syn[j];
    enc_o[OVERALL_POS] = ^enc_o[CW-1:1];
  end
  // Syndrome points at a single flipped position; even overall parity with a syndrome is a double error
  always_comb begin
    dec_syn = '0;
    dec_par = ^cw_i;
    data_o = '0;
    kd = 0;
    for (int p = 1; p < CW; p++)
      if (cw_i[p]) dec_syn = dec_syn ^ p[P-1:0];
    for (int p = 1; p < CW; p++)
      if (!is_parity_pos(p)) begin
        data_o[kd] = cw_i[p] ^ (dec_par && !disable_i && dec_syn == p[P-1:0]);
        kd++;
      end
    status_o = disable_i ? ECC_OK : dec_par ? ECC_CE : (dec_syn != '0) ? ECC_UE : ECC_OK;
  end
endmodule

// File: rtl/nx_ram_1r1w_secded.sv
// nx_ram_1r1w_secded: 1R1W RAM with SECDED, zero-init after reset and saturating error counters
module nx_ram_1r1w_secded
  import nx_ram_ecc_pkg::*;
#(
  parameter int WIDTH = 83,
  parameter int DEPTH = 168,
  parameter int IN_FLOP = 1,
  parameter int RD_LATENCY = 2,
  parameter int WRITETHROUGH = 0,
  parameter int INIT_ON_RESET = 1,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             init_done,
  input  logic             reb,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             web,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] din,
  input  logic             disable_ecc,
  input  logic [1:0]       ecc_corrupt,
  output logic             ro_correctable_ecc_error,
  output logic             ro_uncorrectable_ecc_error,
  output logic             addr_err,
  output logic [AW-1:0]    err_addr,
  output logic [CNT_W-1:0] cerr_cnt,
  output logic [CNT_W-1:0] uerr_cnt,
  input  logic             cnt_clr
);
  localparam int CW = WIDTH + ecc_bits(WIDTH);
  localparam int POS0 = data_pos(0);
  localparam int POS1 = data_pos(WIDTH > 1 ? 1 : 0);
  localparam logic HAS_BIT1 = WIDTH > 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  init_state_e state_q, state_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  logic ra_ok, wa_ok, rd_req, wr_ok;
  logic wv_q;
  logic [AW-1:0] wa_q;
  logic [WIDTH-1:0] din_q;
  logic [1:0] cor_q;
  logic ew_en;
  logic [AW-1:0] ew_addr;
  logic [WIDTH-1:0] ew_din;
  logic [1:0] ew_cor;
  logic [CW-1:0] ew_enc, ew_cw, flip;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  logic [CW-1:0] mem [DEPTH];
  logic v1_q, dis_q;
  logic [AW-1:0] raddr_q;
  logic [CW-1:0] rdata_q;
  logic [WIDTH-1:0] dec_data;
  ecc_status_e dec_st;
  logic dec_ce, dec_ue;
  logic va_q, cea_q, uea_q, vb_q, ceb_q, ueb_q;
  logic [AW-1:0] aa_q, ab_q, out_addr, err_addr_q;
  logic [WIDTH-1:0] da_q, db_q;
  logic [CNT_W-1:0] cerr_q, cerr_d, uerr_q, uerr_d;
  logic addr_err_q;
  logic [WIDTH-1:0] unused_wr_data;
  ecc_status_e unused_wr_st;
  logic [CW-1:0] unused_rd_enc;

  assign init_done = state_q == ST_READY;
  assign ra_ok = {1'b0, ra} < DEPTH_W;
  assign wa_ok = {1'b0, wa} < DEPTH_W;
  assign rd_req = init_done && !reb;
  assign wr_ok = init_done && !web && wa_ok;

  // Init state and sweep address register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INIT_ON_RESET != 0 ? ST_INIT : ST_READY;
      init_addr_q <= '0;
    end else begin
      state_q <= state_d;
      init_addr_q <= init_addr_d;
    end

  // Zero one word per cycle during INIT and leave after the last address
  always_comb begin
    state_d = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == LAST) state_d = ST_READY;
    end
  end

  // Optional input register on the write port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wv_q <= 1'b0;
      wa_q <= '0;
      din_q <= '0;
      cor_q <= '0;
    end else begin
      wv_q <= wr_ok;
      if (wr_ok) begin
        wa_q <= wa;
        din_q <= din;
        cor_q <= ecc_corrupt;
      end
    end

  assign ew_en = IN_FLOP != 0 ? wv_q : wr_ok;
  assign ew_addr = IN_FLOP != 0 ? wa_q : wa;
  assign ew_din = IN_FLOP != 0 ? din_q : din;
  assign ew_cor = IN_FLOP != 0 ? cor_q : ecc_corrupt;

  nx_secded_codec #(.WIDTH(WIDTH)) u_wr_codec (
    .data_i(ew_din), .enc_o(ew_enc), .cw_i('0), .disable_i(1'b1),
    .data_o(unused_wr_data), .status_o(unused_wr_st)
  );

  // Error injection on the encoded word; INIT owns the array write port
  always_comb begin
    flip = '0;
    flip[POS0] = ew_cor[0] ^ ew_cor[1];
    flip[POS1] = flip[POS1] ^ (ew_cor[1] & HAS_BIT1);
    ew_cw = ew_enc ^ flip;
    mem_we = state_q == ST_INIT || ew_en;
    mem_addr = state_q == ST_INIT ? init_addr_q : ew_addr;
    mem_wdata = state_q == ST_INIT ? '0 : ew_cw;
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_wdata;

  // Array read register; out-of-range reads load the all-zero codeword
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q <= 1'b0;
      dis_q <= 1'b0;
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      v1_q <= rd_req;
      if (rd_req) begin
        dis_q <= disable_ecc;
        raddr_q <= ra;
        rdata_q <= !ra_ok ? '0 : (WRITETHROUGH != 0 && ew_en && ew_addr == ra) ? ew_cw : mem[ra];
      end
    end

  nx_secded_codec #(.WIDTH(WIDTH)) u_rd_codec (
    .data_i('0), .enc_o(unused_rd_enc), .cw_i(rdata_q), .disable_i(dis_q),
    .data_o(dec_data), .status_o(dec_st)
  );

  assign dec_ce = v1_q && dec_st == ECC_CE;
  assign dec_ue = v1_q && dec_st == ECC_UE;

  // Output stages after the decoder; data and address hold between reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {va_q, cea_q, uea_q, vb_q, ceb_q, ueb_q} <= '0;
      da_q <= '0;
      db_q <= '0;
      aa_q <= '0;
      ab_q <= '0;
    end else begin
      va_q <= v1_q;
      cea_q <= dec_ce;
      uea_q <= dec_ue;
      if (v1_q) begin
        da_q <= dec_data;
        aa_q <= raddr_q;
      end
      vb_q <= va_q;
      ceb_q <= cea_q;
      ueb_q <= uea_q;
      if (va_q) begin
        db_q <= da_q;
        ab_q <= aa_q;
      end
    end

  // Tap the pipeline at the configured read latency
  always_comb begin
    dout = RD_LATENCY == 1 ? dec_data : RD_LATENCY == 2 ? da_q : db_q;
    dout_vld = RD_LATENCY == 1 ? v1_q : RD_LATENCY == 2 ? va_q : vb_q;
    ro_correctable_ecc_error = RD_LATENCY == 1 ? dec_ce : RD_LATENCY == 2 ? cea_q : ceb_q;
    ro_uncorrectable_ecc_error = RD_LATENCY == 1 ? dec_ue : RD_LATENCY == 2 ? uea_q : ueb_q;
    out_addr = RD_LATENCY == 1 ? raddr_q : RD_LATENCY == 2 ? aa_q : ab_q;
  end

  // Saturating counters; clear takes priority over an increment
  always_comb begin
    cerr_d = cnt_clr ? '0 : (ro_correctable_ecc_error && cerr_q != '1) ? cerr_q + 1'b1 : cerr_q;
    uerr_d = cnt_clr ? '0 : (ro_uncorrectable_ecc_error && uerr_q != '1) ? uerr_q + 1'b1 : uerr_q;
  end

  // Error bookkeeping: counters, last ECC error address, address-range pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cerr_q <= '0;
      uerr_q <= '0;
      err_addr_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      cerr_q <= cerr_d;
      uerr_q <= uerr_d;
      if (ro_correctable_ecc_error || ro_uncorrectable_ecc_error) err_addr_q <= out_addr;
      addr_err_q <= init_done && ((!reb && !ra_ok) || (!web && !wa_ok));
    end

  assign cerr_cnt = cerr_q;
  assign uerr_cnt = uerr_q;
  assign err_addr = err_addr_q;
  assign addr_err = addr_err_q;
endmodule

// File: tb/tb_nx_ram_1r1w_secded.sv
// tb_nx_ram_1r1w_secded: directed vectors for the SECDED RAM in two configurations
module tb_nx_ram_1r1w_secded;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic a_init, a_vld, a_ce, a_ue, a_aerr;
  logic a_reb = 1'b1, a_web = 1'b1, a_dis = 1'b0, a_clr = 1'b0;
  logic [7:0] a_ra = '0, a_wa = '0, a_eaddr;
  logic [82:0] a_din = '0, a_dout;
  logic [1:0] a_cor = '0;
  logic [15:0] a_cc, a_uc;

  logic b_init, b_vld, b_ce, b_ue, b_aerr;
  logic b_reb = 1'b1, b_web = 1'b1, b_dis = 1'b0, b_clr = 1'b0;
  logic [3:0] b_ra = '0, b_wa = '0, b_eaddr;
  logic [7:0] b_din = '0, b_dout;
  logic [1:0] b_cor = '0;
  logic [1:0] b_cc, b_uc;

  nx_ram_1r1w_secded u_a (
    .clk(clk), .rst_n(rst_n), .init_done(a_init), .reb(a_reb), .ra(a_ra), .dout(a_dout),
    .dout_vld(a_vld), .web(a_web), .wa(a_wa), .din(a_din), .disable_ecc(a_dis),
    .ecc_corrupt(a_cor), .ro_correctable_ecc_error(a_ce), .ro_uncorrectable_ecc_error(a_ue),
    .addr_err(a_aerr), .err_addr(a_eaddr), .cerr_cnt(a_cc), .uerr_cnt(a_uc), .cnt_clr(a_clr)
  );

  nx_ram_1r1w_secded #(
    .WIDTH(8), .DEPTH(16), .IN_FLOP(0), .RD_LATENCY(1), .WRITETHROUGH(1), .CNT_W(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .init_done(b_init), .reb(b_reb), .ra(b_ra), .dout(b_dout),
    .dout_vld(b_vld), .web(b_web), .wa(b_wa), .din(b_din), .disable_ecc(b_dis),
    .ecc_corrupt(b_cor), .ro_correctable_ecc_error(b_ce), .ro_uncorrectable_ecc_error(b_ue),
    .addr_err(b_aerr), .err_addr(b_eaddr), .cerr_cnt(b_cc), .uerr_cnt(b_uc), .cnt_clr(b_clr)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [82:0] din;
    logic [1:0]  cor;
    logic        dis;
    logic [82:0] exp;
    logic        ce;
    logic        ue;
  } vec_t;
  vec_t vt [7];

  int checks = 0, errors = 0;
  int exp_c = 0, exp_u = 0;
  int a_rise = 0, b_rise = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic a_write(input logic [7:0] addr, input logic [82:0] data, input logic [1:0] cor);
    a_web = 1'b0;
    a_wa = addr;
    a_din = data;
    a_cor = cor;
    @(negedge clk);
    a_web = 1'b1;
    a_cor = 2'b00;
  endtask

  task automatic a_read(input logic [7:0] addr, input logic dis);
    a_reb = 1'b0;
    a_ra = addr;
    a_dis = dis;
    @(negedge clk);
    a_reb = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vt[0] = '{8'd3, 83'h5A5, 2'b00, 1'b0, 83'h5A5, 1'b0, 1'b0};
    vt[1] = '{8'd3, 83'h5A5, 2'b01, 1'b0, 83'h5A5, 1'b1, 1'b0};
    vt[2] = '{8'd5, 83'h5A5, 2'b10, 1'b0, 83'h5A6, 1'b0, 1'b1};
    vt[3] = '{8'd5, 83'h5A5, 2'b10, 1'b1, 83'h5A6, 1'b0, 1'b0};
    vt[4] = '{8'd7, 83'h5A5, 2'b01, 1'b1, 83'h5A4, 1'b0, 1'b0};
    vt[5] = '{8'd167, {83{1'b1}}, 2'b00, 1'b0, {83{1'b1}}, 1'b0, 1'b0};
    vt[6] = '{8'd100, 83'h4_DEAD_BEEF_0123_4567_89AB, 2'b01, 1'b0, 83'h4_DEAD_BEEF_0123_4567_89AB, 1'b1, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", a_dout, 0);
    chk("rst_vld", a_vld, 0);
    chk("rst_init_a", a_init, 0);
    chk("rst_cerr", a_cc, 0);
    chk("rst_err_addr", a_eaddr, 0);
    chk("rst_init_b", b_init, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (b_init && b_rise == 0) b_rise = i;
      if (a_init) begin
        a_rise = i;
        break;
      end
    end
    chk("init_cycles_a", a_rise, 168);
    chk("init_cycles_b", b_rise, 16);
    @(negedge clk);

    a_read(8'd167, 1'b0);
    chk("init_rd_dout", a_dout, 0);
    chk("init_rd_vld", a_vld, 1);
    chk("init_rd_ce", a_ce, 0);
    chk("init_rd_ue", a_ue, 0);

    for (int i = 0; i < 7; i++) begin
      a_write(vt[i].addr, vt[i].din, vt[i].cor);
      @(negedge clk);
      a_read(vt[i].addr, vt[i].dis);
      chk($sformatf("vec%0d_dout", i), a_dout, vt[i].exp);
      chk($sformatf("vec%0d_vld", i), a_vld, 1);
      chk($sformatf("vec%0d_ce", i), a_ce, vt[i].ce);
      chk($sformatf("vec%0d_ue", i), a_ue, vt[i].ue);
      a_dis = 1'b0;
      @(negedge clk);
      exp_c += int'(vt[i].ce);
      exp_u += int'(vt[i].ue);
      chk($sformatf("vec%0d_vld_pulse", i), a_vld, 0);
      chk($sformatf("vec%0d_hold", i), a_dout, vt[i].exp);
      chk($sformatf("vec%0d_cerr", i), a_cc, exp_c);
      chk($sformatf("vec%0d_uerr", i), a_uc, exp_u);
      if (vt[i].ce || vt[i].ue) chk($sformatf("vec%0d_err_addr", i), a_eaddr, vt[i].addr);
    end

    a_reb = 1'b0;
    a_ra = 8'd200;
    @(negedge clk);
    a_reb = 1'b1;
    chk("oor_rd_addr_err", a_aerr, 1);
    chk("oor_rd_latency", a_vld, 0);
    @(negedge clk);
    chk("oor_rd_dout", a_dout, 0);
    chk("oor_rd_vld", a_vld, 1);
    chk("oor_rd_addr_err_pulse", a_aerr, 0);
    a_write(8'd201, 83'h77, 2'b00);
    chk("oor_wr_addr_err", a_aerr, 1);

    a_write(8'd10, 83'h111, 2'b00);
    @(negedge clk);
    a_web = 1'b0;
    a_wa = 8'd10;
    a_din = 83'h222;
    @(negedge clk);
    a_web = 1'b1;
    a_reb = 1'b0;
    a_ra = 8'd10;
    @(negedge clk);
    a_reb = 1'b1;
    @(negedge clk);
    chk("collide_old", a_dout, 83'h111);
    a_read(8'd10, 1'b0);
    chk("after_collide_new", a_dout, 83'h222);

    b_web = 1'b0;
    b_wa = 4'd2;
    b_din = 8'h3C;
    b_reb = 1'b0;
    b_ra = 4'd2;
    @(negedge clk);
    b_web = 1'b1;
    b_reb = 1'b1;
    chk("wt_collide_new", b_dout, 8'h3C);
    chk("wt_collide_vld", b_vld, 1);

    b_web = 1'b0;
    b_wa = 4'd4;
    b_din = 8'h81;
    b_cor = 2'b01;
    @(negedge clk);
    b_web = 1'b1;
    b_cor = 2'b00;
    b_reb = 1'b0;
    b_ra = 4'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_dout%0d", i), b_dout, 8'h81);
      chk($sformatf("b2b_ce%0d", i), b_ce, 1);
      if (i == 2) chk("b2b_cerr_mid", b_cc, 2);
    end
    b_reb = 1'b1;
    @(negedge clk);
    chk("b2b_vld_end", b_vld, 0);
    @(negedge clk);
    chk("sat_cerr", b_cc, 3);
    chk("sat_err_addr", b_eaddr, 4);

    b_reb = 1'b0;
    @(negedge clk);
    b_reb = 1'b1;
    chk("clr_ce", b_ce, 1);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    chk("clr_wins", b_cc, 0);
    @(negedge clk);
    chk("clr_stays", b_cc, 0);

    a_reb = 1'b0;
    a_ra = 8'd3;
    @(negedge clk);
    a_reb = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld", a_vld, 0);
    chk("rst_mid_init", a_init, 0);
    chk("rst_mid_cerr", a_cc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
